// File: rtl/buscaminas_vga_render.sv
// 640x480@60 VGA renderer for the 8x8 Minesweeper board. It snapshots the board once per frame
// and draws each pixel through a two-stage pipeline: cell lookup, then colour select.
module buscaminas_vga_render (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:7][0:7][8:0] board_out,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank_n,
  output logic [7:0]           vga_r,
  output logic [7:0]           vga_g,
  output logic [7:0]           vga_b,
  output logic                 frame_start
);

  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] H_SYN0 = 10'd656;
  localparam logic [9:0] H_SYN1 = 10'd751;
  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] V_SYN0 = 10'd490;
  localparam logic [9:0] V_SYN1 = 10'd491;
  localparam logic [9:0] V_LAST = 10'd524;
  localparam logic [9:0] BX0    = 10'd128;
  localparam logic [9:0] BX1    = 10'd511;
  localparam logic [9:0] BY0    = 10'd48;
  localparam logic [9:0] BY1    = 10'd431;
  localparam logic [5:0] C_LAST = 6'd47;

  localparam logic [23:0] COL_BG     = 24'h202040;
  localparam logic [23:0] COL_GRID   = 24'h404040;
  localparam logic [23:0] COL_CURSOR = 24'hFFFF00;
  localparam logic [23:0] COL_RED    = 24'hFF0000;
  localparam logic [23:0] COL_OPEN   = 24'hC0C0C0;
  localparam logic [23:0] COL_HIDDEN = 24'h808080;
  localparam logic [23:0] COL_BLACK  = 24'h000000;

  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic [5:0] ox_q, ox_d, oy_q, oy_d;
  logic [2:0] col_q, col_d, row_q, row_d;
  logic       eol;
  logic       snap_load;
  logic [0:7][0:7][8:0] snap_q;
  logic       fs_q;

  logic       s1_vis_q, s1_hs_q, s1_vs_q, s1_board_q;
  logic [5:0] s1_ox_q, s1_oy_q;
  logic [8:0] s1_cell_q;
  logic       s1_vis_d, s1_hs_d, s1_vs_d, s1_board_d;

  logic       hs_q, vs_q, blank_q;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    eol  = (hc_q == H_LAST);
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (eol) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
  end

  // Cell sub-counters track the value held in hc_q/vc_q, so they are reloaded from the next count.
  always_comb begin
    ox_d  = ox_q + 6'd1;
    col_d = col_q;
    if (hc_d == BX0) begin
      ox_d  = '0;
      col_d = '0;
    end else if (ox_q == C_LAST) begin
      ox_d  = '0;
      col_d = col_q + 3'd1;
    end
    oy_d  = oy_q;
    row_d = row_q;
    if (eol) begin
      if (vc_d == BY0) begin
        oy_d  = '0;
        row_d = '0;
      end else if (oy_q == C_LAST) begin
        oy_d  = '0;
        row_d = row_q + 3'd1;
      end else begin
        oy_d = oy_q + 6'd1;
      end
    end
  end

  assign snap_load = (hc_d == 10'd0) && (vc_d == V_VIS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hc_q   <= '0;
      vc_q   <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      snap_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      ox_q  <= ox_d;
      oy_q  <= oy_d;
      col_q <= col_d;
      row_q <= row_d;
      fs_q  <= snap_load;
      if (snap_load) snap_q <= board_out;
    end
  end

  always_comb begin
    s1_vis_d   = (hc_q < H_VIS) && (vc_q < V_VIS);
    s1_hs_d    = !((hc_q >= H_SYN0) && (hc_q <= H_SYN1));
    s1_vs_d    = !((vc_q >= V_SYN0) && (vc_q <= V_SYN1));
    s1_board_d = (hc_q >= BX0) && (hc_q <= BX1) && (vc_q >= BY0) && (vc_q <= BY1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vis_q   <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s1_board_q <= 1'b0;
      s1_ox_q    <= '0;
      s1_oy_q    <= '0;
      s1_cell_q  <= '0;
    end else begin
      s1_vis_q   <= s1_vis_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s1_board_q <= s1_board_d;
      s1_ox_q    <= ox_q;
      s1_oy_q    <= oy_q;
      s1_cell_q  <= snap_q[row_q][col_q];
    end
  end

  // 5x7 digit rows, row 0 on top, bit 4 is the leftmost column.
  function automatic logic [4:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [34:0] g;
    case (d)
      4'd1:    g = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
      4'd2:    g = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
      4'd3:    g = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
      4'd4:    g = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
      4'd5:    g = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
      4'd6:    g = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
      4'd7:    g = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
      4'd8:    g = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
      default: g = '0;
    endcase
    case (r)
      3'd0:    font_row = g[34:30];
      3'd1:    font_row = g[29:25];
      3'd2:    font_row = g[24:20];
      3'd3:    font_row = g[19:15];
      3'd4:    font_row = g[14:10];
      3'd5:    font_row = g[9:5];
      3'd6:    font_row = g[4:0];
      default: font_row = '0;
    endcase
  endfunction

  function automatic logic is_ring(input logic [5:0] v);
    is_ring = (v == 6'd1) || (v == 6'd2) || (v == 6'd45) || (v == 6'd46);
  endfunction

  logic       c_bomb, c_rev, c_mark, c_cur, c_over;
  logic [3:0] c_cnt;
  logic       grid, ring, in_sq, glyph_win, glyph_on;
  logic [2:0] gx, gy;
  logic [7:0] gl_pad;

  always_comb begin
    c_cnt     = s1_cell_q[3:0];
    c_bomb    = s1_cell_q[4];
    c_rev     = s1_cell_q[5];
    c_mark    = s1_cell_q[6];
    c_cur     = s1_cell_q[7];
    c_over    = s1_cell_q[8];
    grid      = (s1_ox_q == 6'd0) || (s1_ox_q == C_LAST) || (s1_oy_q == 6'd0) || (s1_oy_q == C_LAST);
    ring      = is_ring(s1_ox_q) || is_ring(s1_oy_q);
    in_sq     = (s1_ox_q >= 6'd16) && (s1_ox_q <= 6'd31) && (s1_oy_q >= 6'd16) && (s1_oy_q <= 6'd31);
    glyph_win = (s1_ox_q >= 6'd14) && (s1_ox_q <= 6'd33) && (s1_oy_q >= 6'd10) && (s1_oy_q <= 6'd37)
                && (c_cnt >= 4'd1) && (c_cnt <= 4'd8);
    gx        = 3'((s1_ox_q - 6'd14) >> 2);
    gy        = 3'((s1_oy_q - 6'd10) >> 2);
    gl_pad    = {3'b000, font_row(c_cnt, gy)};
    glyph_on  = glyph_win && gl_pad[3'd4 - gx];

    rgb_d = 24'h0;
    if (s1_vis_q) begin
      if (!s1_board_q)                rgb_d = COL_BG;
      else if (grid)                  rgb_d = COL_GRID;
      else if (c_cur && ring)         rgb_d = COL_CURSOR;
      else if (c_bomb && (c_rev || c_over)) rgb_d = in_sq ? COL_BLACK : COL_RED;
      else if (c_rev)                 rgb_d = glyph_on ? COL_BLACK : COL_OPEN;
      else if (c_mark)                rgb_d = in_sq ? COL_RED : COL_HIDDEN;
      else                            rgb_d = COL_HIDDEN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hs_q    <= s1_hs_q;
      vs_q    <= s1_vs_q;
      blank_q <= s1_vis_q;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign blank_n     = blank_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign frame_start = fs_q;

endmodule

// File: tb/tb_buscaminas_vga_render.sv
// Bench for buscaminas_vga_render: a raster-position model drives a pixel scoreboard,
// plus whole-frame sync/blank totals.
module tb_buscaminas_vga_render;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [0:7][0:7][8:0] board;
  logic                 hsync, vsync, blank_n, frame_start;
  logic [7:0]           vga_r, vga_g, vga_b;

  always #20 clk = ~clk;

  buscaminas_vga_render dut (
    .clk         (clk),
    .rst         (rst),
    .board_out   (board),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          fr;
    int          x;
    int          y;
    logic [24:0] exp;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t ent;

  function automatic void push(input int fr, input int x, input int y, input logic [24:0] e, input string tag);
    exp_t t;
    t.fr = fr; t.x = x; t.y = y; t.exp = e; t.tag = tag;
    sb_q.push_back(t);
  endfunction

  // Raster position model: cur = counter value, d1/d2 = positions one and two cycles back.
  int cur_hc = 0, cur_vc = 0, cur_fr = 0;
  int d1_hc = 0, d1_vc = 0, d1_fr = 0;
  int d2_hc = 0, d2_vc = 0, d2_fr = 0;
  bit d1_v = 0, d2_v = 0;

  always @(posedge clk) begin
    if (!rst) begin
      cur_hc <= 0; cur_vc <= 0;
      d1_v <= 0; d2_v <= 0;
    end else begin
      d2_hc <= d1_hc; d2_vc <= d1_vc; d2_fr <= d1_fr; d2_v <= d1_v;
      d1_hc <= cur_hc; d1_vc <= cur_vc; d1_fr <= cur_fr; d1_v <= 1'b1;
      if (cur_hc == 799) begin
        cur_hc <= 0;
        if (cur_vc == 524) begin
          cur_vc <= 0;
          cur_fr <= cur_fr + 1;
        end else begin
          cur_vc <= cur_vc + 1;
        end
      end else begin
        cur_hc <= cur_hc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (d2_v && sb_q.size() > 0 && sb_q[0].fr == d2_fr && sb_q[0].x == d2_hc && sb_q[0].y == d2_vc) begin
      ent = sb_q.pop_front();
      chk(ent.tag, {7'b0, blank_n, vga_r, vga_g, vga_b}, {7'b0, ent.exp});
    end
    if (rst && frame_start)
      chk("fs_pos", 32'(cur_vc * 1000 + cur_hc), 32'd480000);
  end

  // Totals over the first 420000 output cycles after reset release.
  int win = 0, hs_low = 0, vs_low = 0, bl_hi = 0, fs_cnt = 0;
  int hs_run = 0, first_run = 0, fall1 = -1, fall2 = -1;
  logic prev_hs = 1'b1;

  always @(negedge clk) begin
    if (rst && win < 420000) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (blank_n) bl_hi++;
      if (frame_start) fs_cnt++;
      if (!hsync) hs_run++;
      else if (hs_run > 0) begin
        if (first_run == 0) first_run = hs_run;
        hs_run = 0;
      end
      if (prev_hs && !hsync) begin
        if (fall1 < 0) fall1 = win;
        else if (fall2 < 0) fall2 = win;
      end
      prev_hs = hsync;
      win++;
    end
  end

  task automatic wait_pos(input int fr, input int v);
    int n = 0;
    while (!(cur_fr == fr && cur_vc == v) && n < 1000000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pos", 32'(cur_fr == fr && cur_vc == v), 32'd1);
  endtask

  localparam logic [24:0] P_BG   = {1'b1, 24'h202040};
  localparam logic [24:0] P_GRID = {1'b1, 24'h404040};
  localparam logic [24:0] P_CUR  = {1'b1, 24'hFFFF00};
  localparam logic [24:0] P_RED  = {1'b1, 24'hFF0000};
  localparam logic [24:0] P_OPEN = {1'b1, 24'hC0C0C0};
  localparam logic [24:0] P_HID  = {1'b1, 24'h808080};
  localparam logic [24:0] P_BLK  = {1'b1, 24'h000000};
  localparam logic [24:0] P_OFF  = 25'h0;

  initial begin
    int n;
    rst   = 1'b0;
    board = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {5'b0, hsync, vsync, blank_n, vga_r, vga_g, vga_b}, {5'b0, 1'b1, 1'b1, 1'b0, 24'h0});

    push(0, 0,   0,   P_BG,   "f0_first_px");
    push(0, 700, 10,  P_OFF,  "f0_hblank");
    push(0, 150, 70,  P_HID,  "f0_cell00_hidden");
    push(0, 320, 200, P_GRID, "f0_grid");
    push(0, 334, 202, P_HID,  "f0_digit_not_yet");
    push(0, 488, 408, P_HID,  "f0_bomb_not_yet");

    @(posedge clk);
    #5 rst = 1'b1;
    @(posedge clk);
    #1 chk("lat1_blank", {31'b0, blank_n}, 32'd0);

    wait_pos(0, 100);
    board[0][0] = 9'h020;
    board[3][4] = 9'h023;
    board[2][5] = 9'h0C0;
    board[7][7] = 9'h110;
    push(1, 150, 70,  P_OPEN, "f1_cell00_open");
    push(1, 369, 150, P_CUR,  "f1_cursor_ring");
    push(1, 380, 160, P_HID,  "f1_flag_bg");
    push(1, 392, 168, P_RED,  "f1_flag_sq");
    push(1, 320, 200, P_GRID, "f1_grid");
    push(1, 334, 202, P_BLK,  "f1_glyph_lit_r0");
    push(1, 334, 206, P_OPEN, "f1_glyph_unlit");
    push(1, 342, 210, P_BLK,  "f1_glyph_lit_r2");
    push(1, 470, 390, P_RED,  "f1_bomb_bg");
    push(1, 488, 408, P_BLK,  "f1_bomb_sq");

    n = 0;
    while (win < 420000 && n < 500000) begin
      @(negedge clk);
      n++;
    end
    chk("win_done",   32'(win), 32'd420000);
    chk("hs_low_tot", 32'(hs_low), 32'd50400);
    chk("vs_low_tot", 32'(vs_low), 32'd1600);
    chk("blank_tot",  32'(bl_hi), 32'd307200);
    chk("fs_count",   32'(fs_cnt), 32'd1);
    chk("hs_width",   32'(first_run), 32'd96);
    chk("hs_period",  32'(fall2 - fall1), 32'd800);

    wait_pos(1, 100);
    board[7][7] = 9'h010;
    push(2, 150, 70,  P_OPEN, "f2_cell00_open");
    push(2, 470, 390, P_HID,  "f2_nogo_bg");
    push(2, 488, 408, P_HID,  "f2_nogo_sq");

    n = 0;
    while (sb_q.size() > 0 && n < 900000) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/buscaminas_vga_render.md
# buscaminas_vga_render

Display-side consumer of the Minesweeper game core's `board_out` array. It generates 640x480@60 Hz VGA timing and takes a tear-free snapshot of the 8x8 board once per frame. It renders every pixel (grid, hidden/marked/revealed cells, digit glyphs, bombs, cursor) as 24-bit RGB. It sits between the game core and the board's VGA DAC, and only reads the board.

## Interface
Parameters:
- none; geometry and colours are fixed by this spec.

Ports:
- `clk` in 1: 25.175 MHz pixel clock; the single clock domain.
- `rst` in 1: reset, synchronous, active-low.
- `board_out` in 9 x [0:7][0:7]: cell word per cell, `[row][col]`:
  - [3:0] adjacent-bomb count
  - [4] bomb
  - [5] revealed
  - [6] marked
  - [7] cursor
  - [8] game over
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `blank_n` out 1: high while the pixel is in the visible area.
- `vga_r`, `vga_g`, `vga_b` out 8 each: pixel colour; 0 when `blank_n` is 0.
- `frame_start` out 1: one-cycle pulse when the board snapshot is taken.

## Operation
- **Horizontal counter `hc`, 0..799:**
  - visible 0-639
  - front porch 640-655
  - sync 656-751
  - back porch 752-799
- **Vertical counter `vc`, 0..524:**
  - visible 0-479
  - front porch 480-489
  - sync 490-491
  - back porch 492-524
- **Counter stepping:** `vc` increments when `hc` wraps from 799 to 0. Both counters wrap to 0 after (799, 524).
- **Snapshot:**
  - At `hc`=0, `vc`=480, all 64 cell words are copied into an internal 576-bit register and `frame_start` pulses.
  - Rendering reads only the snapshot, so mid-frame changes on `board_out` never appear until the next frame.
- **Board region:** x 128-511, y 48-431, with 48x48-pixel cells.
  - Column = (x-128)/48 and row = (y-48)/48; cell offsets ox and oy run 0..47.
  - Column/ox and row/oy are tracked by sub-counters loaded at the region edges. No dividers.
- **Colour priority, highest first**, for visible pixels:
  1. Outside the board region: 0x202040.
  2. Grid line (ox or oy equal to 0 or 47): 0x404040.
  3. Cursor ring (cursor bit set; ox or oy in {1,2,45,46}): 0xFFFF00.
  4. Bomb shown (bomb bit set and either revealed or game-over): red background 0xFF0000 with a black square at ox,oy 16-31.
  5. Revealed, not a bomb: background 0xC0C0C0.
     - Count 1-8: a 5x7 digit glyph scaled x4 (20x28) at ox 14-33, oy 10-37, glyph pixels 0x000000.
     - Count 0 or 9-15: no glyph.
  6. Hidden and marked: 0x808080 with a red 0xFF0000 square at ox,oy 16-31.
  7. Hidden: 0x808080.
- **Font:** an internal combinational ROM holds digit glyphs 1-8. Glyph column gx = (ox-14)>>2, glyph row gy = (oy-10)>>2.

## Timing
- **Pipeline, 2 stages:**
  - Stage 1: counters to cell index, offsets and region flags, plus snapshot lookup.
  - Stage 2: colour select and registered outputs.
- `hsync`, `vsync` and `blank_n` are delayed by the same 2 cycles. All outputs are registered, and the pixel for counter value (hc, vc) appears 2 cycles after that value.
- `frame_start` is registered and aligned to the counter, not to the pixel pipeline. It is high exactly 1 cycle per 420,000.
- **Reset:**
  - Counters go to 0 and the snapshot to all-zero (all cells hidden, unmarked).
  - `hsync`=1, `vsync`=1, `blank_n`=0, RGB=0, `frame_start`=0. Pipeline registers are cleared.
  - Reset applied mid-frame restarts at (0,0) on the first cycle after `rst` returns high, with no partial-line artefacts beyond blanked output.
- **Sync levels:** `hsync` is low for `hc` 656-751 and `vsync` is low for `vc` 490-491, both after the 2-cycle delay.

## Test plan
- **Reset:** hold `rst`=0 for 5 cycles. Required: `hsync`=`vsync`=1, `blank_n`=0, RGB=0. Release; first visible pixel (0,0) appears 2 cycles later, colour 0x202040.
- **Timing:** count one frame. Required:
  - `hsync` low for 96 cycles every 800.
  - `vsync` low for 1600 cycles every 420,000.
  - `blank_n` high for 640 cycles per line on 480 lines.
  - `frame_start` pulses once.
- **Snapshot:** set cell (0,0)=9'h020 (revealed, count 0) at `vc`=100.
  - Required: pixel (150,70) stays 0x808080 for the rest of this frame.
  - After the next `frame_start`, the same pixel becomes 0xC0C0C0 in the following frame.
- **Digit:** cell (3,4)=9'h023 (revealed, 3) snapshotted.
  - Cell origin is (320,192).
  - Required: a lit glyph pixel renders 0x000000, an unlit glyph pixel 0xC0C0C0, and grid pixel (320,200) 0x404040.
- **Cursor/flag:** cell (2,5)=9'h0C0 (cursor, marked).
  - Required: (369,150)=0xFFFF00, (392,168)=0xFF0000, (380,160)=0x808080.
- **Game over:** cell (7,7)=9'h110 (bomb, hidden, game over).
  - Required: (488,408)=0x000000 and (470,390)=0xFF0000.
  - Required: with bit 8 cleared, both pixels are 0x808080.
